divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 30 +++
 rtl/divider_signfix.sv | 65 ++++++
 rtl/divider.sv | 138 +++++++++++++
 tb/tb_divider.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the iterative integer divider: data width, the
// RISC-V div_type encodings and the controller state enum.
package divider_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    DIV   = 2'b00,
    DIVU  = 2'b01,
    DIVW  = 2'b10,
    DIVUW = 2'b11
  } div_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // bit1 selects the 32-bit word form, bit0 selects unsigned
  function automatic logic is_word(input logic [1:0] t);
    return t[1];
  endfunction

  function automatic logic is_signed(input logic [1:0] t);
    return !t[0];
  endfunction

endpackage

// File: rtl/divider_signfix.sv
// Combinational sign handling around the unsigned divider core: operand
// magnitudes, special-case detection, result sign correction and word sign-extension.
module div_signfix
  import divider_pkg::*;
(
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [1:0]      op_type,
  input  logic            rem_sel,
  input  logic [XLEN-1:0] raw_q,
  input  logic [XLEN-1:0] raw_r,
  output logic [XLEN-1:0] a_mag,
  output logic [XLEN-1:0] b_mag,
  output logic            div_zero,
  output logic            overflow,
  output logic [XLEN-1:0] fixed
);

  logic            word;
  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [31:0]     a_w;
  logic [31:0]     b_w;
  logic [XLEN-1:0] q_val;
  logic [XLEN-1:0] r_val;
  logic [XLEN-1:0] sel;

  always_comb begin
    word  = is_word(op_type);
    sgn   = is_signed(op_type);
    a_w   = op_a[31:0];
    b_w   = op_b[31:0];
    a_neg = sgn && (word ? op_a[31] : op_a[XLEN-1]);
    b_neg = sgn && (word ? op_b[31] : op_b[XLEN-1]);

    if (word) begin
      a_mag    = {32'b0, (a_neg ? -a_w : a_w)};
      b_mag    = {32'b0, (b_neg ? -b_w : b_w)};
      div_zero = (b_w == 32'b0);
      overflow = sgn && (a_w == 32'h8000_0000) && (b_w == 32'hFFFF_FFFF);
    end else begin
      a_mag    = a_neg ? -op_a : op_a;
      b_mag    = b_neg ? -op_b : op_b;
      div_zero = (op_b == '0);
      overflow = sgn && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    end

    // special cases bypass the iterative result entirely
    if (div_zero) begin
      q_val = '1;
      r_val = op_a;
    end else if (overflow) begin
      q_val = op_a;
      r_val = '0;
    end else begin
      q_val = (a_neg ^ b_neg) ? -raw_q : raw_q;
      r_val = a_neg ? -raw_r : raw_r;
    end

    sel   = rem_sel ? r_val : q_val;
    fixed = word ? {{32{sel[31]}}, sel[31:0]} : sel;
  end

endmodule

// File: rtl/divider.sv
// Restoring radix-2 divider for div/divu/divw/divuw with valid/ready handshakes,
// one quotient bit per clock; divide-by-zero and signed overflow resolve in one CALC cycle.
module divider
  import divider_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [1:0]      div_type,
  input  logic            rem_sel,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output state_t          fsm_state
);

  // Handshakes: an operation transfers on an edge with in_valid && in_ready,
  // a result on an edge with out_valid && out_ready; both sides may hold
  // valid indefinitely and the block holds its outputs stable while waiting.

  state_t            state;
  state_t            state_d;
  logic [XLEN-1:0]   dividend_q;
  logic [XLEN-1:0]   divisor_q;
  logic [1:0]        type_q;
  logic              rem_sel_q;
  logic [XLEN-1:0]   quo_r;
  logic [XLEN-1:0]   rem_r;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   result_r;

  logic              accept;
  logic              last_iter;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [1:0]        op_type;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div_zero;
  logic              overflow;
  logic [XLEN-1:0]   fixed;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic              ge;
  logic [XLEN-1:0]   quo_d;
  logic [XLEN-1:0]   rem_d;

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_r;
  assign fsm_state = state;

  // In IDLE the sign-fix block looks at the live inputs so the dividend
  // magnitude can be loaded on the accepting edge; afterwards it sees the captured copy.
  assign op_a    = (state == IDLE) ? dividend : dividend_q;
  assign op_b    = (state == IDLE) ? divisor  : divisor_q;
  assign op_type = (state == IDLE) ? div_type : type_q;

  div_signfix u_signfix (
    .op_a     (op_a),
    .op_b     (op_b),
    .op_type  (op_type),
    .rem_sel  (rem_sel_q),
    .raw_q    (quo_d),
    .raw_r    (rem_d),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .div_zero (div_zero),
    .overflow (overflow),
    .fixed    (fixed)
  );

  // One restoring step; the dividend is left-aligned in quo_r so word and
  // doubleword share the same shift path.
  always_comb begin
    shifted = {rem_r, quo_r[XLEN-1]};
    ge      = (shifted >= {1'b0, b_mag});
    diff    = shifted - {1'b0, b_mag};
    rem_d   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_d   = {quo_r[XLEN-2:0], ge};
  end

  assign last_iter = (cnt == (is_word(type_q) ? CNT_W'(31) : CNT_W'(63)));

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = CALC;
      CALC: if (div_zero || overflow || last_iter) state_d = DONE;
      DONE: if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      type_q     <= '0;
      rem_sel_q  <= 1'b0;
      quo_r      <= '0;
      rem_r      <= '0;
      cnt        <= '0;
      result_r   <= '0;
    end else begin
      state <= state_d;
      if (!flush) begin
        if (accept) begin
          dividend_q <= dividend;
          divisor_q  <= divisor;
          type_q     <= div_type;
          rem_sel_q  <= rem_sel;
          cnt        <= '0;
          rem_r      <= '0;
          quo_r      <= is_word(div_type) ? {a_mag[31:0], 32'b0} : a_mag;
        end
        if (state == CALC) begin
          if (!(div_zero || overflow)) begin
            quo_r <= quo_d;
            rem_r <= rem_d;
            cnt   <= cnt + CNT_W'(1);
          end
          if (state_d == DONE) result_r <= fixed;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the divider: results, latencies, special cases,
// result hold under back-pressure, flush and mid-operation reset.
module tb_divider;
  import divider_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [1:0]      div_type;
  logic            rem_sel;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;
  state_t          fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];

  divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .div_type  (div_type),
    .rem_sel   (rem_sel),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Waits for in_ready, presents one operation and returns just after the accepting edge
  // with the operand inputs scrambled, so later input changes are exercised.
  task automatic accept_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [1:0] t, input logic rs);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    dividend = a;
    divisor  = b;
    div_type = t;
    rem_sel  = rs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    div_type = 2'($urandom_range(0, 3));
    rem_sel  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] t, input logic rs, input logic [63:0] exp_res,
                        input int exp_lat, input int hold);
    int edges;
    logic [63:0] exp;
    exp_q.push_back(exp_res);
    accept_op(tag, a, b, t, rs);
    edges = 1;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
    end
    exp = exp_q.pop_front();
    check({tag, " latency"}, 64'(edges), 64'(exp_lat));
    check({tag, " result"}, result, exp);
    check({tag, " in_ready in DONE"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold result"}, result, exp);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid after consume"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready after consume"}, 64'(in_ready), 64'd1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check({tag, " out_valid never rose"}, 64'(seen), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    div_type  = DIV;
    rem_sel   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", result, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset state", 64'(fsm_state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    run_op("div -7/2 q", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("div -7/2 r", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divu max/16 q", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, DIVU, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divu max/16 r", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, DIVU, 1'b1, 64'hF, 65, 0);
    run_op("divu 5/0 q", 64'd5, 64'd0, DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    run_op("divu 5/0 r", 64'd5, 64'd0, DIVU, 1'b1, 64'd5, 2, 0);
    run_op("div ovf q", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, DIV, 1'b0, 64'h8000_0000_0000_0000, 2, 0);
    run_op("div ovf r", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, DIV, 1'b1, 64'd0, 2, 0);
    run_op("divw ovf q", 64'h8000_0000, 64'hFFFF_FFFF, DIVW, 1'b0, 64'hFFFF_FFFF_8000_0000, 2, 0);
    run_op("divuw sext", 64'hAAAA_BBBB_FFFF_FFFE, 64'd1, DIVUW, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    run_op("divw 100/-7 q", 64'd100, 64'h0000_0000_FFFF_FFF9, DIVW, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 33, 0);
    run_op("divw 100/-7 r", 64'd100, 64'h0000_0000_FFFF_FFF9, DIVW, 1'b1, 64'd2, 33, 0);
    run_op("divuw 2^31/2", 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_0000_0002, DIVUW, 1'b0, 64'h4000_0000, 33, 0);
    run_op("divw /0 r", 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, DIVW, 1'b1, 64'hFFFF_FFFF_8000_0001, 2, 0);
    run_op("div 100/7 hold", 64'd100, 64'd7, DIV, 1'b0, 64'd14, 65, 5);

    // flush ten edges into CALC
    accept_op("flush", 64'd1000, 64'd3, DIV, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush in_ready", 64'(in_ready), 64'd1);
    check("flush busy", 64'(busy), 64'd0);
    check("flush out_valid", 64'(out_valid), 64'd0);
    watch_no_valid("flush", 80);

    // reset in the middle of an operation drops it
    accept_op("mid-reset", 64'd77, 64'd5, DIVU, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid-reset in_ready", 64'(in_ready), 64'd0);
    check("mid-reset state", 64'(fsm_state), 64'(IDLE));
    check("mid-reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid-reset in_ready after", 64'(in_ready), 64'd1);
    watch_no_valid("mid-reset", 80);

    run_op("after reset divu 77/5", 64'd77, 64'd5, DIVU, 1'b1, 64'd2, 65, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
